// File: rtl/rvarb_rr3.sv
// rvarb_rr3: round-robin arbiter for one shared downstream resource.
// Issues a registered one-hot grant. The grant is held until the owner
// releases the resource or drops its request. A watchdog revokes the grant
// after MAX_HOLD cycles. Every output is flop-driven.
// The per-requester done pulse is named 'rel' because 'release' is a
// reserved word in SystemVerilog.
module rvarb_rr3 #(
    parameter int N        = 3,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 15,
    parameter int CW       = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   rel,
    output logic [N-1:0]   gnt,
    output logic           gnt_vld,
    output logic [IDW-1:0] gnt_id,
    output logic           timeout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Last hold_cnt value before a revoke. It is unused when the watchdog is disabled.
    localparam int               HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
    localparam logic [CW-1:0]    HOLD_LAST   = CW'(HOLD_LAST_I);
    localparam logic [IDW-1:0]   PTR_RST     = IDW'(N - 1);
    localparam logic [N-1:0]     ONE_N       = {{(N-1){1'b0}}, 1'b1};

    state_t          state_r, state_s;
    logic [IDW-1:0]  ptr_r, ptr_s;
    logic [CW-1:0]   hold_cnt_r, hold_cnt_s;
    logic [N-1:0]    gnt_r, gnt_s;
    logic            gnt_vld_r, gnt_vld_s;
    logic [IDW-1:0]  gnt_id_r, gnt_id_s;
    logic            timeout_r, timeout_s;

    logic            win_vld_s;
    logic [IDW-1:0]  win_id_s;
    logic            own_exit_s;
    logic            wd_hit_s;

    // Round-robin pick: return {found, index} for the first set bit of r.
    // The search starts at (p+1) mod N and wraps around.
    function automatic logic [IDW:0] rr_pick(input logic [N-1:0] r, input logic [IDW-1:0] p);
        logic           found;
        logic [IDW-1:0] id;
        int             idx;
        found = 1'b0;
        id    = '0;
        for (int i = 1; i <= N; i++) begin
            idx = int'(p) + i;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (!found && r[idx[IDW-1:0]]) begin
                found = 1'b1;
                id    = idx[IDW-1:0];
            end else begin
                found = found;
            end
        end
        return {found, id};
    endfunction

    // Winner selection and owner exit/watchdog conditions.
    always_comb begin
        {win_vld_s, win_id_s} = rr_pick(req, ptr_r);
        own_exit_s = rel[gnt_id_r] || !req[gnt_id_r];
        wd_hit_s   = (MAX_HOLD != 0) && (hold_cnt_r == HOLD_LAST);
    end

    // Next-state and next-output logic for the IDLE/HOLD controller.
    always_comb begin
        state_s    = state_r;
        ptr_s      = ptr_r;
        hold_cnt_s = hold_cnt_r;
        gnt_s      = gnt_r;
        gnt_vld_s  = gnt_vld_r;
        gnt_id_s   = gnt_id_r;
        timeout_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (win_vld_s) begin
                    gnt_s      = ONE_N << win_id_s;
                    gnt_vld_s  = 1'b1;
                    gnt_id_s   = win_id_s;
                    ptr_s      = win_id_s;
                    hold_cnt_s = '0;
                    state_s    = HOLD;
                end else begin
                    gnt_s     = '0;
                    gnt_vld_s = 1'b0;
                end
            end
            HOLD: begin
                // A voluntary exit wins over the watchdog on the same cycle.
                if (own_exit_s) begin
                    gnt_s     = '0;
                    gnt_vld_s = 1'b0;
                    state_s   = IDLE;
                end else if (wd_hit_s) begin
                    gnt_s     = '0;
                    gnt_vld_s = 1'b0;
                    timeout_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    hold_cnt_s = hold_cnt_r + CW'(1);
                end
            end
            default: begin
                gnt_s     = '0;
                gnt_vld_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State and output registers. Reset is asynchronous and active-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            ptr_r      <= PTR_RST;
            hold_cnt_r <= '0;
            gnt_r      <= '0;
            gnt_vld_r  <= 1'b0;
            gnt_id_r   <= '0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            hold_cnt_r <= hold_cnt_s;
            gnt_r      <= gnt_s;
            gnt_vld_r  <= gnt_vld_s;
            gnt_id_r   <= gnt_id_s;
            timeout_r  <= timeout_s;
        end
    end

    assign gnt     = gnt_r;
    assign gnt_vld = gnt_vld_r;
    assign gnt_id  = gnt_id_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_rvarb_rr3.sv
// Self-checking bench for rvarb_rr3. It uses a directed vector table for
// rotation and ignore rules, and hand-written sequences for the watchdog,
// asynchronous reset and the N=5 wrap-around search.
module tb_rvarb_rr3;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req, rel, gnt;
    logic       gnt_vld, timeout;
    logic [1:0] gnt_id;
    logic [4:0] req5, rel5, gnt5;
    logic       gnt_vld5, timeout5;
    logic [2:0] gnt_id5;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [2:0] req;
        logic [2:0] rel;
        logic [2:0] gnt;
        logic       vld;
        logic [1:0] id;
        logic       to;
    } vec_t;

    vec_t tbl[14];

    rvarb_rr3 #(.N(3), .IDW(2), .MAX_HOLD(15), .CW(4)) u_dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel),
        .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id), .timeout(timeout)
    );

    rvarb_rr3 #(.N(5), .IDW(3), .MAX_HOLD(15), .CW(4)) u_dut5 (
        .clk(clk), .rst(rst), .req(req5), .rel(rel5),
        .gnt(gnt5), .gnt_vld(gnt_vld5), .gnt_id(gnt_id5), .timeout(timeout5)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk3(input string nm, input logic [2:0] g, input logic v,
                        input logic [1:0] id, input logic to);
        chk({nm, "_gnt"}, 32'(gnt), 32'(g));
        chk({nm, "_vld"}, 32'(gnt_vld), 32'(v));
        chk({nm, "_id"}, 32'(gnt_id), 32'(id));
        chk({nm, "_to"}, 32'(timeout), 32'(to));
    endtask

    initial begin
        // Rotation with owner release, then non-owner and IDLE releases ignored.
        tbl[0]  = '{3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0};
        tbl[1]  = '{3'b111, 3'b001, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[2]  = '{3'b111, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0};
        tbl[3]  = '{3'b111, 3'b010, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[4]  = '{3'b111, 3'b000, 3'b100, 1'b1, 2'd2, 1'b0};
        tbl[5]  = '{3'b111, 3'b100, 3'b000, 1'b0, 2'd2, 1'b0};
        tbl[6]  = '{3'b111, 3'b000, 3'b001, 1'b1, 2'd0, 1'b0};
        tbl[7]  = '{3'b111, 3'b010, 3'b001, 1'b1, 2'd0, 1'b0};
        tbl[8]  = '{3'b110, 3'b000, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[9]  = '{3'b110, 3'b000, 3'b010, 1'b1, 2'd1, 1'b0};
        tbl[10] = '{3'b110, 3'b101, 3'b010, 1'b1, 2'd1, 1'b0};
        tbl[11] = '{3'b101, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[12] = '{3'b000, 3'b000, 3'b000, 1'b0, 2'd1, 1'b0};
        tbl[13] = '{3'b000, 3'b111, 3'b000, 1'b0, 2'd1, 1'b0};

        rst = 1'b1; req = '0; rel = '0; req5 = '0; rel5 = '0;
        #12;
        chk3("reset", 3'b000, 1'b0, 2'd0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors: the inputs are applied, one edge passes, then the outputs are compared.
        for (int i = 0; i < 14; i++) begin
            req = tbl[i].req;
            rel = tbl[i].rel;
            step();
            chk3($sformatf("v%0d", i), tbl[i].gnt, tbl[i].vld, tbl[i].id, tbl[i].to);
        end
        rel = '0;

        // Watchdog: the only requester holds for exactly 15 cycles, is revoked, then is re-granted.
        req = 3'b001;
        for (int c = 1; c <= 15; c++) begin
            step();
            chk3($sformatf("wd_hold%0d", c), 3'b001, 1'b1, 2'd0, 1'b0);
        end
        step();
        chk3("wd_revoke", 3'b000, 1'b0, 2'd0, 1'b1);
        step();
        chk3("wd_regrant", 3'b001, 1'b1, 2'd0, 1'b0);

        // A release on the limit cycle is a voluntary exit, so timeout stays low.
        for (int c = 0; c < 14; c++) begin
            step();
        end
        chk3("wd_pre_limit", 3'b001, 1'b1, 2'd0, 1'b0);
        rel = 3'b001;
        step();
        chk3("wd_rel_limit", 3'b000, 1'b0, 2'd0, 1'b0);
        rel = 3'b000;
        step();
        chk3("wd_rel_regrant", 3'b001, 1'b1, 2'd0, 1'b0);

        // Make requester 2 the owner, then apply an asynchronous reset mid-cycle.
        req = 3'b100;
        step();
        chk3("pre_rst_drop", 3'b000, 1'b0, 2'd0, 1'b0);
        step();
        chk3("pre_rst_own2", 3'b100, 1'b1, 2'd2, 1'b0);
        step();
        chk3("pre_rst_hold2", 3'b100, 1'b1, 2'd2, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk3("async_rst", 3'b000, 1'b0, 2'd0, 1'b0);
        req = 3'b110;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk3("post_rst_ptr", 3'b010, 1'b1, 2'd1, 1'b0);

        // N=5: release owner 4, then the search wraps from index 0.
        req5 = 5'b10000;
        step();
        chk("n5_own4_gnt", 32'(gnt5), 32'(5'b10000));
        chk("n5_own4_id", 32'(gnt_id5), 32'd4);
        rel5 = 5'b10000;
        step();
        chk("n5_rel_gnt", 32'(gnt5), 32'(5'b00000));
        chk("n5_rel_to", 32'(timeout5), 32'd0);
        rel5 = 5'b00000;
        req5 = 5'b10001;
        step();
        chk("n5_wrap_gnt", 32'(gnt5), 32'(5'b00001));
        chk("n5_wrap_id", 32'(gnt_id5), 32'd0);
        chk("n5_wrap_vld", 32'(gnt_vld5), 32'd1);
        req5 = 5'b10010;
        step();
        chk("n5_drop0_gnt", 32'(gnt5), 32'(5'b00000));
        step();
        chk("n5_next1_gnt", 32'(gnt5), 32'(5'b00010));
        chk("n5_next1_id", 32'(gnt_id5), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
